// File: rtl/riscv_v_wb_buffer.sv
`default_nettype none
// ============================================================================
// riscv_v_wb_buffer : in-order writeback FIFO retiring vector / v2i results
// Rev 1.0
// ============================================================================
module riscv_v_wb_buffer #(
  parameter int VLEN   = 128,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_exe,
  output logic                    ready_exe,
  input  logic                    is_v2i_exe,
  input  logic [VLEN-1:0]         vec_result_exe,
  input  logic [XLEN-1:0]         int_result_exe,
  input  logic [REG_AW-1:0]       dst_addr_exe,
  input  logic [VLEN/8-1:0]       byte_en_exe,
  output logic                    vrf_wr_en,
  input  logic                    vrf_wr_ready,
  output logic [REG_AW-1:0]       vrf_wr_addr,
  output logic [VLEN-1:0]         vrf_wr_data,
  output logic [VLEN/8-1:0]       vrf_wr_be,
  output logic                    int_wr_en,
  input  logic                    int_wr_ready,
  output logic [REG_AW-1:0]       int_wr_addr,
  output logic [XLEN-1:0]         int_wr_data,
  output logic [(1<<REG_AW)-1:0]  pending_vreg,
  output logic                    wb_idle
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int BEW = VLEN / 8;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic [DEPTH-1:0]  valid_q,  valid_d;
  logic [DEPTH-1:0]  v2i_q,    v2i_d;
  logic [VLEN-1:0]   vec_q [DEPTH];
  logic [VLEN-1:0]   vec_d [DEPTH];
  logic [XLEN-1:0]   int_q [DEPTH];
  logic [XLEN-1:0]   int_d [DEPTH];
  logic [REG_AW-1:0] dst_q [DEPTH];
  logic [REG_AW-1:0] dst_d [DEPTH];
  logic [BEW-1:0]    be_q  [DEPTH];
  logic [BEW-1:0]    be_d  [DEPTH];

  logic head_live;
  logic head_v2i;
  logic head_masked;
  logic drop;
  logic enq;
  logic deq;

  // Head decode; everything is gated by rst so nothing is presented in a reset cycle.
  always_comb begin
    head_live   = rst && valid_q[rd_ptr_q];
    head_v2i    = v2i_q[rd_ptr_q];
    head_masked = ~|be_q[rd_ptr_q];

    vrf_wr_en   = head_live && !head_v2i && !head_masked;
    int_wr_en   = head_live && head_v2i;
    drop        = head_live && !head_v2i && head_masked;

    vrf_wr_addr = '0;
    vrf_wr_data = '0;
    vrf_wr_be   = '0;
    int_wr_addr = '0;
    int_wr_data = '0;
    if (head_live && !head_v2i) begin
      vrf_wr_addr = dst_q[rd_ptr_q];
      vrf_wr_data = vec_q[rd_ptr_q];
      vrf_wr_be   = be_q[rd_ptr_q];
    end
    if (head_live && head_v2i) begin
      int_wr_addr = dst_q[rd_ptr_q];
      int_wr_data = int_q[rd_ptr_q];
    end

    deq       = (vrf_wr_en && vrf_wr_ready) || (int_wr_en && int_wr_ready) || drop;
    ready_exe = rst && (count_q != FULL_CNT);
    enq       = valid_exe && ready_exe;
    wb_idle   = !rst || (count_q == '0);
  end

  always_comb begin
    pending_vreg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rst && valid_q[i] && !v2i_q[i]) begin
        pending_vreg[dst_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    v2i_d    = v2i_q;
    vec_d    = vec_q;
    int_d    = int_q;
    dst_d    = dst_q;
    be_d     = be_q;

    // Dequeue first so a simultaneous enqueue into the same slot cannot be cleared.
    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      v2i_d[wr_ptr_q]   = is_v2i_exe;
      vec_d[wr_ptr_q]   = vec_result_exe;
      int_d[wr_ptr_q]   = int_result_exe;
      dst_d[wr_ptr_q]   = dst_addr_exe;
      be_d[wr_ptr_q]    = byte_en_exe;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset: it is only ever observed behind a set valid bit.
  always_ff @(posedge clk) begin
    v2i_q <= v2i_d;
    vec_q <= vec_d;
    int_q <= int_d;
    dst_q <= dst_d;
    be_q  <= be_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_wb_buffer.sv
`default_nettype none
// ============================================================================
// tb_riscv_v_wb_buffer : directed stimulus with queue reference model
// Rev 1.0
// ============================================================================
module tb_riscv_v_wb_buffer;

  localparam int VLEN   = 128;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int REG_AW = 5;
  localparam int BEW    = VLEN / 8;
  localparam int NREG   = 1 << REG_AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_exe;
  logic              ready_exe;
  logic              is_v2i_exe;
  logic [VLEN-1:0]   vec_result_exe;
  logic [XLEN-1:0]   int_result_exe;
  logic [REG_AW-1:0] dst_addr_exe;
  logic [BEW-1:0]    byte_en_exe;
  logic              vrf_wr_en;
  logic              vrf_wr_ready;
  logic [REG_AW-1:0] vrf_wr_addr;
  logic [VLEN-1:0]   vrf_wr_data;
  logic [BEW-1:0]    vrf_wr_be;
  logic              int_wr_en;
  logic              int_wr_ready;
  logic [REG_AW-1:0] int_wr_addr;
  logic [XLEN-1:0]   int_wr_data;
  logic [NREG-1:0]   pending_vreg;
  logic              wb_idle;

  riscv_v_wb_buffer #(
    .VLEN(VLEN), .XLEN(XLEN), .DEPTH(DEPTH), .REG_AW(REG_AW)
  ) dut (
    .clk(clk), .rst(rst),
    .valid_exe(valid_exe), .ready_exe(ready_exe),
    .is_v2i_exe(is_v2i_exe), .vec_result_exe(vec_result_exe),
    .int_result_exe(int_result_exe), .dst_addr_exe(dst_addr_exe),
    .byte_en_exe(byte_en_exe),
    .vrf_wr_en(vrf_wr_en), .vrf_wr_ready(vrf_wr_ready),
    .vrf_wr_addr(vrf_wr_addr), .vrf_wr_data(vrf_wr_data), .vrf_wr_be(vrf_wr_be),
    .int_wr_en(int_wr_en), .int_wr_ready(int_wr_ready),
    .int_wr_addr(int_wr_addr), .int_wr_data(int_wr_data),
    .pending_vreg(pending_vreg), .wb_idle(wb_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit                v2i;
    logic [VLEN-1:0]   vec;
    logic [XLEN-1:0]   ival;
    logic [REG_AW-1:0] dst;
    logic [BEW-1:0]    be;
  } ent_t;

  ent_t mq[$];

  // Reference model: an in-order queue advanced on each rising edge.
  always @(posedge clk) begin
    bit   acc;
    bit   rel;
    ent_t e;
    if (!rst) begin
      mq.delete();
    end else begin
      acc = valid_exe && (mq.size() < DEPTH);
      rel = 1'b0;
      if (mq.size() > 0) begin
        if (mq[0].v2i)          rel = int_wr_ready;
        else if (mq[0].be == 0) rel = 1'b1;
        else                    rel = vrf_wr_ready;
      end
      checks++;
      if (dut.count_q == DEPTH && dut.enq) begin
        errors++;
        $display("FAIL count_overflow: enqueue with count %0d at %0t", dut.count_q, $time);
      end
      checks++;
      if (dut.count_q == 0 && dut.deq) begin
        errors++;
        $display("FAIL count_underflow: dequeue with count %0d at %0t", dut.count_q, $time);
      end
      if (rel) void'(mq.pop_front());
      if (acc) begin
        e.v2i  = is_v2i_exe;
        e.vec  = vec_result_exe;
        e.ival = int_result_exe;
        e.dst  = dst_addr_exe;
        e.be   = byte_en_exe;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit            hv;
    bit            ev;
    bit            ei;
    logic [NREG-1:0] ep;
    hv = rst && (mq.size() > 0);
    ev = hv && !mq[0].v2i && (mq[0].be != 0);
    ei = hv && mq[0].v2i;
    ep = '0;
    if (rst) foreach (mq[k]) if (!mq[k].v2i) ep[mq[k].dst] = 1'b1;
    check("ready_exe", ready_exe, rst && (mq.size() != DEPTH));
    check("vrf_wr_en", vrf_wr_en, ev);
    check("int_wr_en", int_wr_en, ei);
    check("wb_idle", wb_idle, !rst || (mq.size() == 0));
    check("pending_vreg", pending_vreg, ep);
    if (ev) begin
      check("vrf_wr_addr", vrf_wr_addr, mq[0].dst);
      check("vrf_wr_data", vrf_wr_data, mq[0].vec);
      check("vrf_wr_be", vrf_wr_be, mq[0].be);
    end
    if (ei) begin
      check("int_wr_addr", int_wr_addr, mq[0].dst);
      check("int_wr_data", int_wr_data, mq[0].ival);
    end
    if (!hv) begin
      check("idle_vrf_data", {vrf_wr_addr, vrf_wr_data, vrf_wr_be}, '0);
      check("idle_int_data", {int_wr_addr, int_wr_data}, '0);
    end
  end

  function automatic logic [VLEN-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 | k;
    return {(VLEN/32){w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v2i, input int dst, input logic [VLEN-1:0] vec,
                       input logic [XLEN-1:0] ival, input logic [BEW-1:0] be);
    valid_exe      = 1'b1;
    is_v2i_exe     = v2i;
    dst_addr_exe   = REG_AW'(dst);
    vec_result_exe = vec;
    int_result_exe = ival;
    byte_en_exe    = be;
  endtask

  logic [BEW-1:0]  all_be;
  logic [VLEN-1:0] a5;

  initial begin
    all_be = '1;
    a5     = {BEW{8'hA5}};
    rst = 1'b0; valid_exe = 1'b0; is_v2i_exe = 1'b0; vec_result_exe = '0;
    int_result_exe = '0; dst_addr_exe = '0; byte_en_exe = '0;
    vrf_wr_ready = 1'b1; int_wr_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("lit_reset_ready", ready_exe, 1'b0);
    check("lit_reset_idle", wb_idle, 1'b1);
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    check("lit_post_reset_ready", ready_exe, 1'b1);

    // Single vector result
    drive(0, 3, a5, 0, all_be);
    tick();
    valid_exe = 1'b0;
    @(negedge clk);
    check("lit_single_en", vrf_wr_en, 1'b1);
    check("lit_single_addr", vrf_wr_addr, 5'd3);
    check("lit_single_data", vrf_wr_data, a5);
    check("lit_single_pending", pending_vreg, 32'h0000_0008);
    tick();
    @(negedge clk);
    check("lit_single_idle", wb_idle, 1'b1);

    // Backpressure fill then in-order drain
    vrf_wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(0, i, pat(i), 0, all_be);
      tick();
    end
    valid_exe = 1'b0;
    @(negedge clk);
    check("lit_full_ready", ready_exe, 1'b0);
    check("lit_full_pending", pending_vreg, 32'h0000_001E);
    tick(); tick();
    @(negedge clk);
    check("lit_stall_addr", vrf_wr_addr, 5'd1);
    check("lit_stall_data", vrf_wr_data, pat(1));
    tick();
    vrf_wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("lit_drain_addr", vrf_wr_addr, 5'(i));
      tick();
    end
    @(negedge clk);
    check("lit_drain_idle", wb_idle, 1'b1);

    // Mixed order with scalar stall
    int_wr_ready = 1'b0;
    drive(0, 5, pat(5), 0, all_be); tick();
    drive(1, 7, '0, 32'h0000_1234, '0); tick();
    drive(0, 6, pat(6), 0, all_be); tick();
    valid_exe = 1'b0;
    @(negedge clk);
    check("lit_x7_en", int_wr_en, 1'b1);
    check("lit_x7_data", int_wr_data, 32'h0000_1234);
    check("lit_x7_addr", int_wr_addr, 5'd7);
    check("lit_v6_blocked", vrf_wr_en, 1'b0);
    check("lit_v6_pending", pending_vreg, 32'h0000_0040);
    tick();
    int_wr_ready = 1'b1;
    tick();
    @(negedge clk);
    check("lit_v6_after", vrf_wr_addr, 5'd6);
    tick();
    @(negedge clk);
    check("lit_mixed_idle", wb_idle, 1'b1);

    // Fully masked drop, then partial byte enables
    drive(0, 9, pat(9), 0, '0); tick();
    valid_exe = 1'b0;
    @(negedge clk);
    check("lit_drop_en", vrf_wr_en, 1'b0);
    check("lit_drop_pending", pending_vreg, 32'h0000_0200);
    tick();
    @(negedge clk);
    check("lit_drop_cleared", pending_vreg, 32'h0);
    drive(0, 10, pat(10), 0, 16'h00FF); tick();
    valid_exe = 1'b0;
    @(negedge clk);
    check("lit_partial_be", vrf_wr_be, 16'h00FF);
    tick();

    // Full with simultaneous dequeue: enqueue refused, then accepted next cycle
    vrf_wr_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      drive(0, i, pat(i), 0, all_be);
      tick();
    end
    drive(0, 15, pat(15), 0, all_be);
    vrf_wr_ready = 1'b1;
    @(negedge clk);
    check("lit_full_refuse", ready_exe, 1'b0);
    tick();
    @(negedge clk);
    check("lit_reopen_ready", ready_exe, 1'b1);
    tick();
    valid_exe = 1'b0;
    vrf_wr_ready = 1'b0;
    @(negedge clk);
    check("lit_count_three", dut.count_q, 3);
    check("lit_head_13", vrf_wr_addr, 5'd13);
    tick();
    vrf_wr_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    check("lit_full_idle", wb_idle, 1'b1);

    // Reset mid-stream discards buffered entries
    vrf_wr_ready = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      drive(0, i, pat(i), 0, all_be);
      tick();
    end
    valid_exe = 1'b0;
    rst = 1'b0;
    vrf_wr_ready = 1'b1;
    @(negedge clk);
    check("lit_rst_en", vrf_wr_en, 1'b0);
    check("lit_rst_pending", pending_vreg, 32'h0);
    check("lit_rst_idle", wb_idle, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("lit_after_rst_en", vrf_wr_en, 1'b0);
    check("lit_after_rst_idle", wb_idle, 1'b1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end, limit %0d ns", 100000);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/riscv_v_wb_buffer.md
Name: riscv_v_wb_buffer

Overview:
- Writeback-side consumer of the vector execute stage: captures each completed vector or scalar (v2i) result with its destination and byte enables.
- Buffers results in a small in-order FIFO and retires them to the vector register file write port or the integer register file write port, honouring per-port backpressure.
- Publishes a pending-destination bitmap so issue logic can stall RAW hazards on vector registers still in flight.

Parameters:
- VLEN, 128, vector result width in bits (= RISCV_V_DATA_WIDTH); multiple of 8.
- XLEN, 32, integer result width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- valid_exe  input  1  execute result valid.
- ready_exe  output  1  buffer can accept a result.
- is_v2i_exe  input  1  result targets the integer RF; otherwise the vector RF.
- vec_result_exe  input  VLEN  vector result data.
- int_result_exe  input  XLEN  scalar result data.
- dst_addr_exe  input  REG_AW  destination register.
- byte_en_exe  input  VLEN/8  vector byte enables (mask and vl already applied upstream).
- vrf_wr_en  output  1  vector RF write valid.
- vrf_wr_ready  input  1  vector RF accepts write.
- vrf_wr_addr  output  REG_AW  vector RF write address.
- vrf_wr_data  output  VLEN  vector RF write data.
- vrf_wr_be  output  VLEN/8  vector RF byte enables.
- int_wr_en  output  1  integer RF write valid.
- int_wr_ready  input  1  integer RF accepts write.
- int_wr_addr  output  REG_AW  integer RF write address.
- int_wr_data  output  XLEN  integer RF write data.
- pending_vreg  output  2^REG_AW  bit r set while any buffered vector entry targets v[r].
- wb_idle  output  1  FIFO empty.

Behaviour:
- Reset (rst=0 at a clk edge):
  - wr_ptr, rd_ptr and count clear to 0; all entry valid bits clear.
  - vrf_wr_en, int_wr_en, pending_vreg and ready_exe drive 0; all data and address outputs drive 0.
  - wb_idle = 1.
  - Reset asserted mid-operation discards all buffered entries. No write is issued in the reset cycle or the cycle after.
- ready_exe:
  - Equals rst && (count != DEPTH).
  - Registered-count based; it has no combinational path from vrf_wr_ready or int_wr_ready.
  - An enqueue is never accepted while full, even if a dequeue happens in the same cycle.
- Enqueue: valid_exe && ready_exe. Store {is_v2i, vec_result, int_result, dst_addr, byte_en} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Show-ahead head, driven from registered FIFO storage:
  - Scalar head (is_v2i): int_wr_en=1, int_wr_addr and int_wr_data from the head; vrf_wr_en=0.
  - Vector head with byte_en != 0: vrf_wr_en=1 with addr, data and be from the head; int_wr_en=0.
  - Vector head with byte_en == 0 (fully masked): neither enable asserts. The entry dequeues silently in its first head cycle.
  - Empty FIFO: both enables 0 and data outputs hold 0.
- Dequeue condition: (vrf_wr_en && vrf_wr_ready) || (int_wr_en && int_wr_ready) || silent drop. On dequeue, rd_ptr increments and wraps.
- Outputs are stable while the write enable is asserted and ready is low (no data change, no withdrawal).
- Latency: a result accepted at edge N presents at the write port in the cycle after edge N when the FIFO was empty. One retirement per cycle maximum. Retirement is strictly in order, so a stalled scalar head blocks later vector entries and vice versa.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Count:
  - +1 on enqueue only, -1 on dequeue only.
  - Increment at DEPTH and decrement at 0 are impossible by construction; a bench assertion checks both.
- pending_vreg: combinational OR over valid, non-v2i entries of the one-hot decode of dst_addr. A bit clears only when the last entry for that register dequeues. Silent-drop entries count as pending until they dequeue.
- wb_idle = (count == 0).

Test Plan:
- Reset then single vector result: valid_exe=1, dst=3, be=all-ones, data=0xA5.., vrf_wr_ready=1 -> next cycle vrf_wr_en=1, addr=3, data=0xA5..; pending_vreg[3]=1 for one cycle; then wb_idle=1.
- Backpressure fill: vrf_wr_ready=0, enqueue 4 vector results to v1..v4 -> ready_exe=0 after the 4th; pending_vreg=0x1E; head holds v1 data stable. Release ready -> v1..v4 retire on 4 consecutive cycles in order.
- Mixed order: vector v5, scalar x7=0x1234, vector v6, with int_wr_ready=0 for 3 cycles -> v5 retires; x7 stalls and blocks v6; after int_wr_ready=1, x7 then v6 retire.
- Masked drop: vector entry with be=0 to v9 -> no vrf_wr_en, pending_vreg[9] clears one cycle after presentation. A partial be=0x00FF passes unchanged to vrf_wr_be.
- Full plus simultaneous: FIFO full, head retiring, valid_exe=1 -> enqueue refused (ready_exe=0); next cycle ready_exe=1 and enqueue with dequeue keeps count=3.
- Reset mid-stream: 3 entries buffered, rst=0 for one cycle -> all enables 0, pending_vreg=0, wb_idle=1; buffered entries are never written.
